// File: rtl/mmcm_drp_ctrl.sv
`timescale 1ns/1ps
// MMCM run-time reconfiguration over DRP: holds RST, read-modify-writes the
// selected mode's register table from an external ROM, then waits for LOCKED.
module mmcm_drp_ctrl #(
    parameter int  NUM_REGS     = 23,
    parameter int  MODE_W       = 2,
    parameter int  RST_HOLD     = 8,
    parameter int  DRP_TIMEOUT  = 64,
    parameter int  LOCK_TIMEOUT = 100000,
    localparam int IDX_W        = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_req,
    input  logic [MODE_W-1:0]       cfg_mode,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic [MODE_W+IDX_W-1:0] tbl_addr,
    input  logic [38:0]             tbl_data,
    output logic [6:0]              drp_daddr,
    output logic [15:0]             drp_di,
    input  logic [15:0]             drp_do,
    output logic                    drp_den,
    output logic                    drp_dwe,
    input  logic                    drp_drdy,
    output logic                    mmcm_rst,
    input  logic                    mmcm_locked
);

    localparam int RC_W = $clog2(RST_HOLD) + 1;
    localparam int TC_W = $clog2(DRP_TIMEOUT) + 1;
    localparam int LC_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_HOLD - 1);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(DRP_TIMEOUT - 1);
    localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(LOCK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RST   = 4'd1;
    localparam logic [3:0] S_FETCH = 4'd2;
    localparam logic [3:0] S_FLAT  = 4'd3;
    localparam logic [3:0] S_READ  = 4'd4;
    localparam logic [3:0] S_RWAIT = 4'd5;
    localparam logic [3:0] S_WRITE = 4'd6;
    localparam logic [3:0] S_WWAIT = 4'd7;
    localparam logic [3:0] S_REL   = 4'd8;
    localparam logic [3:0] S_LWAIT = 4'd9;
    localparam logic [3:0] S_DONE  = 4'd10;
    localparam logic [3:0] S_ERR   = 4'd11;

    logic [3:0]              state_q, state_d;
    logic [MODE_W-1:0]       mode_q, mode_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
    logic [RC_W-1:0]         rc_q, rc_d;
    logic [TC_W-1:0]         tc_q, tc_d;
    logic [LC_W-1:0]         lc_q, lc_d;
    logic [15:0]             mask_q, mask_d;
    logic [15:0]             val_q, val_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    den_q, den_d;
    logic                    dwe_q, dwe_d;
    logic                    mrst_q, mrst_d;
    logic [MODE_W+IDX_W-1:0] taddr_q, taddr_d;
    logic [6:0]              daddr_q, daddr_d;
    logic [15:0]             di_q, di_d;
    logic                    lock_meta_q, lock_sync_q;
    logic                    go_err;

    assign idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        rc_d    = rc_q;
        tc_d    = tc_q;
        lc_d    = lc_q;
        mask_d  = mask_q;
        val_d   = val_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        den_d   = 1'b0;
        dwe_d   = 1'b0;
        mrst_d  = mrst_q;
        taddr_d = taddr_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        go_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    mode_d  = cfg_mode;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    rc_d    = '0;
                    mrst_d  = 1'b1;
                    state_d = S_RST;
                end
            end
            S_RST: begin
                if (rc_q == RC_LAST) begin
                    taddr_d = {mode_q, idx_q};
                    state_d = S_FETCH;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_FETCH: state_d = S_FLAT;
            S_FLAT: begin
                daddr_d = tbl_data[38:32];
                mask_d  = tbl_data[31:16];
                val_d   = tbl_data[15:0];
                den_d   = 1'b1;
                state_d = S_READ;
            end
            S_READ: begin
                tc_d    = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                // mask bit set keeps the bit read back from the MMCM
                if (drp_drdy) begin
                    di_d    = (drp_do & mask_q) | (val_q & ~mask_q);
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = S_WRITE;
                end else if (tc_q == TC_LAST) begin
                    go_err = 1'b1;
                end else if (tc_q != '1) begin
                    tc_d = tc_q + TC_W'(1);
                end
            end
            S_WRITE: begin
                tc_d    = '0;
                state_d = S_WWAIT;
            end
            S_WWAIT: begin
                if (drp_drdy) begin
                    if (idx_q == IDX_LAST) begin
                        mrst_d  = 1'b0;
                        state_d = S_REL;
                    end else begin
                        idx_d   = idx_inc;
                        taddr_d = {mode_q, idx_inc};
                        state_d = S_FETCH;
                    end
                end else if (tc_q == TC_LAST) begin
                    go_err = 1'b1;
                end else if (tc_q != '1) begin
                    tc_d = tc_q + TC_W'(1);
                end
            end
            S_REL: begin
                lc_d    = '0;
                state_d = S_LWAIT;
            end
            S_LWAIT: begin
                // counter keeps running across lock glitches
                if (lock_sync_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (lc_q == LC_LAST) begin
                    go_err = 1'b1;
                end else if (lc_q != '1) begin
                    lc_d = lc_q + LC_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (go_err) begin
            mrst_d  = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            idx_q       <= '0;
            rc_q        <= '0;
            tc_q        <= '0;
            lc_q        <= '0;
            mask_q      <= '0;
            val_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            mrst_q      <= 1'b0;
            taddr_q     <= '0;
            daddr_q     <= '0;
            di_q        <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            rc_q        <= rc_d;
            tc_q        <= tc_d;
            lc_q        <= lc_d;
            mask_q      <= mask_d;
            val_q       <= val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            mrst_q      <= mrst_d;
            taddr_q     <= taddr_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            lock_meta_q <= mmcm_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign tbl_addr  = taddr_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign mmcm_rst  = mrst_q;

endmodule
